// File: rtl/usb2_slvfifo_pkg.sv
// Shared types and constants for the USB2 slave-FIFO read path.
//   WORD_W       : slave-FIFO data bus width
//   EPx_ADDR     : usb_fifoaddr encodings for the four endpoints
//   rd_state_e   : read-controller state encoding
package usb2_slvfifo_pkg;

    localparam int unsigned WORD_W = 16;

    localparam logic [1:0] EP2_ADDR = 2'b00;
    localparam logic [1:0] EP4_ADDR = 2'b01;
    localparam logic [1:0] EP6_ADDR = 2'b10;
    localparam logic [1:0] EP8_ADDR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        READ = 2'd2,
        FIN  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/usb2_slvfifo_rd_ctrl_if.sv
// Slave-FIFO pin bundle plus the downstream valid/ready word stream.
//   master : FPGA read controller (drives FIFO control pins and stream data)
//   slave  : Cypress FIFO side / stream consumer
interface usb2_slvfifo_rd_ctrl_if;

    logic [1:0]                          usb_fifoaddr;
    logic                                usb_slcs;
    logic                                usb_sloe;
    logic                                usb_slrd;
    logic [usb2_slvfifo_pkg::WORD_W-1:0] usb_fd;
    logic                                usb_flaga;
    logic [usb2_slvfifo_pkg::WORD_W-1:0] m_data;
    logic                                m_valid;
    logic                                m_ready;

    modport master (
        output usb_fifoaddr, usb_slcs, usb_sloe, usb_slrd,
        input  usb_fd, usb_flaga,
        output m_data, m_valid,
        input  m_ready
    );

    modport slave (
        input  usb_fifoaddr, usb_slcs, usb_sloe, usb_slrd,
        output usb_fd, usb_flaga,
        input  m_data, m_valid,
        output m_ready
    );

endinterface

// File: rtl/usb2_rd_buf.sv
// Small synchronous word FIFO with a registered head word.
//   usb_clk, rst_n   : clock, async active-low reset
//   push, push_data  : write one word
//   pop              : consume the head word (only while head_valid)
//   head_data/valid  : registered head of the buffer
//   free_cnt_c       : free entries, combinational from the occupancy count
module usb2_rd_buf
    import usb2_slvfifo_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                          usb_clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [WORD_W-1:0]             push_data,
    input  logic                          pop,
    output logic [WORD_W-1:0]             head_data,
    output logic                          head_valid,
    output logic [$clog2(DEPTH):0]        free_cnt_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_ptr_nxt;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic [WORD_W-1:0] head_nxt;

    assign free_cnt_c = CW'(DEPTH) - count;

    // Next head: a word pushed into the slot that becomes the head bypasses mem.
    always_comb begin
        rd_ptr_nxt = rd_ptr + AW'(pop);
        count_nxt  = count + CW'(push) - CW'(pop);
        head_nxt   = mem[rd_ptr_nxt];
        if (push && (wr_ptr == rd_ptr_nxt)) begin
            head_nxt = push_data;
        end
    end

    // Storage array, not reset.
    always_ff @(posedge usb_clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge usb_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_data  <= '0;
            head_valid <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + AW'(push);
            rd_ptr     <= rd_ptr_nxt;
            count      <= count_nxt;
            head_data  <= head_nxt;
            head_valid <= (count_nxt != '0);
        end
    end

    // Overflow/underflow can only come from a broken strobe throttle upstream.
    always_ff @(posedge usb_clk) begin
        if (rst_n) begin
            assert (!(push && !pop && (count == CW'(DEPTH))));
            assert (!(pop && (count == '0)));
        end
    end

endmodule

// File: rtl/usb2_slvfifo_rd_ctrl.sv
// Slave-FIFO read master: strobes words out of the Cypress FIFO, buffers them
// and presents them on a valid/ready stream.
//   usb_clk, rst_n  : interface clock, async active-low reset
//   start/cfg_words : begin a transfer of cfg_words words (accepted in IDLE)
//   bus             : slave-FIFO pins and m_data/m_valid/m_ready stream
//   busy/done       : transfer active / one-cycle completion pulse
//   word_cnt        : words captured in the current transfer
//   rd_sum          : sum of captured words (only with USB_RD_CHECKSUM_EN)
module usb2_slvfifo_rd_ctrl
    import usb2_slvfifo_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter logic [1:0]  EP_ADDR = 2'b00
) (
    input  logic                         usb_clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [15:0]                  cfg_words,
    usb2_slvfifo_rd_ctrl_if.master       bus,
    output logic                         busy,
    output logic                         done,
`ifdef USB_RD_CHECKSUM_EN
    output logic [15:0]                  rd_sum,
`endif
    output logic [15:0]                  word_cnt
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    rd_state_e     state;
    logic [15:0]   len;
    logic [CW-1:0] free_c;
    logic          capture_c;
    logic          pop_c;
    logic          slrd_nxt_c;

    // A word lands on every edge where the strobe is low and the FIFO has data.
    assign capture_c = (state == READ) && !bus.usb_slrd && bus.usb_flaga;
    assign pop_c     = bus.m_valid && bus.m_ready;

    // Strobe throttle: room for this read plus the one possibly in flight,
    // and never request past len.
    always_comb begin
        slrd_nxt_c = 1'b1;
        if ((state == READ) && bus.usb_flaga && (free_c >= CW'(2)) &&
            ((word_cnt + 16'(!bus.usb_slrd)) < len)) begin
            slrd_nxt_c = 1'b0;
        end
    end

    usb2_rd_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .usb_clk    (usb_clk),
        .rst_n      (rst_n),
        .push       (capture_c),
        .push_data  (bus.usb_fd),
        .pop        (pop_c),
        .head_data  (bus.m_data),
        .head_valid (bus.m_valid),
        .free_cnt_c (free_c)
    );

    // Control FSM with registered pin and status outputs.
    always_ff @(posedge usb_clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            len              <= '0;
            word_cnt         <= '0;
            bus.usb_slcs     <= 1'b1;
            bus.usb_sloe     <= 1'b1;
            bus.usb_slrd     <= 1'b1;
            bus.usb_fifoaddr <= 2'b00;
            busy             <= 1'b0;
            done             <= 1'b0;
`ifdef USB_RD_CHECKSUM_EN
            rd_sum           <= '0;
`endif
        end else begin
            bus.usb_slrd <= slrd_nxt_c;
            done         <= 1'b0;
            if (capture_c) begin
                word_cnt <= word_cnt + 16'd1;
`ifdef USB_RD_CHECKSUM_EN
                rd_sum   <= rd_sum + bus.usb_fd;
`endif
            end
            case (state)
                IDLE: begin
                    if (start) begin
`ifdef USB_RD_CHECKSUM_EN
                        rd_sum <= '0;
`endif
                        if (cfg_words == 16'd0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            len              <= cfg_words;
                            word_cnt         <= '0;
                            state            <= ARM;
                            bus.usb_slcs     <= 1'b0;
                            bus.usb_sloe     <= 1'b0;
                            bus.usb_fifoaddr <= EP_ADDR;
                            busy             <= 1'b1;
                        end
                    end
                end
                ARM: begin
                    state <= READ;
                end
                READ: begin
                    if (capture_c && ((word_cnt + 16'd1) == len)) begin
                        state            <= FIN;
                        done             <= 1'b1;
                        busy             <= 1'b0;
                        bus.usb_slcs     <= 1'b1;
                        bus.usb_sloe     <= 1'b1;
                        bus.usb_fifoaddr <= 2'b00;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb2_slvfifo_rd_ctrl.sv
// Directed bench for usb2_slvfifo_rd_ctrl with a simple slave-FIFO source
// holding words 0..255 and a stream monitor on the output side.
module tb_usb2_slvfifo_rd_ctrl;
    import usb2_slvfifo_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam logic [1:0]  EP    = EP6_ADDR;

    logic        usb_clk   = 1'b0;
    logic        rst_n     = 1'b0;
    logic        start     = 1'b0;
    logic [15:0] cfg_words = '0;
    logic        busy;
    logic        done;
    logic [15:0] word_cnt;
`ifdef USB_RD_CHECKSUM_EN
    logic [15:0] rd_sum;
`endif

    usb2_slvfifo_rd_ctrl_if bus();

    always #5 usb_clk = ~usb_clk;

    usb2_slvfifo_rd_ctrl #(
        .DEPTH   (DEPTH),
        .EP_ADDR (EP)
    ) dut (
        .usb_clk   (usb_clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_words (cfg_words),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
`ifdef USB_RD_CHECKSUM_EN
        .rd_sum    (rd_sum),
`endif
        .word_cnt  (word_cnt)
    );

    // Source: 256 words valued 0..255, one popped per strobed edge with data.
    logic        vip_rst = 1'b1;
    logic [16:0] vip_idx;
    always @(posedge usb_clk) begin
        if (vip_rst)                            vip_idx <= '0;
        else if (!bus.usb_slrd && bus.usb_flaga) vip_idx <= vip_idx + 17'd1;
    end
    assign bus.usb_flaga = !vip_rst && (vip_idx < 17'd256);
    assign bus.usb_fd    = vip_idx[15:0];

    // Consumer: always ready, or ready one cycle in four.
    int         ready_mode = 0;
    logic [1:0] bp_phase   = '0;
    always @(posedge usb_clk) begin
        #1;
        bp_phase    = bp_phase + 2'd1;
        bus.m_ready = (ready_mode == 0) || (bp_phase == 2'd0);
    end

    // Monitor: stream order, captures, strobes, done pulses, modelled occupancy.
    logic mon_clr = 1'b1;
    int   recv, bad, caps, rd_low, dones, occ, occ_max;
    always @(negedge usb_clk) begin
        if (mon_clr) begin
            recv = 0; bad = 0; caps = 0; rd_low = 0; dones = 0; occ = 0; occ_max = 0;
        end else begin
            if (bus.m_valid && bus.m_ready) begin
                if (bus.m_data != 16'(recv)) bad = bad + 1;
                recv = recv + 1;
                occ  = occ - 1;
            end
            if (!bus.usb_slrd && bus.usb_flaga) begin
                caps = caps + 1;
                occ  = occ + 1;
            end
            if (!bus.usb_slrd) rd_low = rd_low + 1;
            if (done)          dones  = dones + 1;
            if (occ > occ_max) occ_max = occ;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_xfer(input logic [15:0] n);
        @(posedge usb_clk); #1;
        cfg_words = n;
        start     = 1'b1;
        @(posedge usb_clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int ok);
        int n;
        ok = 0;
        n  = 0;
        while (!ok && n < budget) begin
            @(negedge usb_clk);
            if (done) ok = 1;
            n = n + 1;
        end
    endtask

    task automatic wait_recv(input int want, input int budget);
        int n;
        n = 0;
        while (recv < want && n < budget) begin
            @(posedge usb_clk); #1;
            n = n + 1;
        end
        repeat (4) @(posedge usb_clk);
        #1;
    endtask

    task automatic vip_restart();
        vip_rst = 1'b1;
        mon_clr = 1'b1;
        repeat (2) @(posedge usb_clk);
        #1;
        vip_rst = 1'b0;
        mon_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        vip_rst = 1'b1;
        mon_clr = 1'b1;
        repeat (3) @(posedge usb_clk);
        #1;
        rst_n   = 1'b1;
        vip_rst = 1'b0;
        mon_clr = 1'b0;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_slcs"},     bus.usb_slcs,     1);
        check({pfx, "_sloe"},     bus.usb_sloe,     1);
        check({pfx, "_slrd"},     bus.usb_slrd,     1);
        check({pfx, "_fifoaddr"}, bus.usb_fifoaddr, 0);
        check({pfx, "_m_valid"},  bus.m_valid,      0);
        check({pfx, "_busy"},     busy,             0);
        check({pfx, "_done"},     done,             0);
        check({pfx, "_word_cnt"}, word_cnt,         0);
    endtask

    task automatic check_arm(input string pfx);
        check({pfx, "_arm_slcs"},     bus.usb_slcs,     0);
        check({pfx, "_arm_sloe"},     bus.usb_sloe,     0);
        check({pfx, "_arm_fifoaddr"}, bus.usb_fifoaddr, 32'(EP));
        check({pfx, "_arm_busy"},     busy,             1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ok;
        int n;

        // Reset state
        repeat (3) @(posedge usb_clk);
        #1;
        check_reset_vals("rst");
        rst_n   = 1'b1;
        vip_rst = 1'b0;
        mon_clr = 1'b0;

        // Full 256-word transfer
        start_xfer(16'd256);
        check_arm("full");
        wait_done(3000, ok);
        check("full_done_seen", ok, 1);
        check("full_word_cnt", word_cnt, 256);
        check("full_slrd_end", bus.usb_slrd, 1);
        check("full_busy_fin", busy, 0);
        check("full_slcs_fin", bus.usb_slcs, 1);
        check("full_addr_fin", bus.usb_fifoaddr, 0);
`ifdef USB_RD_CHECKSUM_EN
        check("full_rd_sum", rd_sum, 32'h7F80);
`endif
        wait_recv(256, 3000);
        check("full_recv", recv, 256);
        check("full_order", bad, 0);
        check("full_caps", caps, 256);
        check("full_dones", dones, 1);

        // Partial transfer of 100 words
        vip_restart();
        start_xfer(16'd100);
        wait_done(3000, ok);
        check("part_done_seen", ok, 1);
        check("part_word_cnt", word_cnt, 100);
        wait_recv(100, 3000);
        check("part_recv", recv, 100);
        check("part_order", bad, 0);
        check("part_caps", caps, 100);
        check("part_strobes", rd_low, 100);
        check("part_busy", busy, 0);
        check("part_dones", dones, 1);

        // Backpressure: ready one cycle in four
        vip_restart();
        ready_mode = 1;
        start_xfer(16'd256);
        wait_done(5000, ok);
        check("bp_done_seen", ok, 1);
        wait_recv(256, 5000);
        check("bp_recv", recv, 256);
        check("bp_order", bad, 0);
        check("bp_caps", caps, 256);
        check("bp_no_overflow", occ_max <= DEPTH, 1);
        check("bp_dones", dones, 1);
        ready_mode = 0;

        // Source runs dry: ask for 300, only 256 exist
        vip_restart();
        start_xfer(16'd300);
        n = 0;
        while (caps < 256 && n < 3000) begin
            @(posedge usb_clk); #1;
            n = n + 1;
        end
        repeat (20) @(posedge usb_clk);
        #1;
        check("dry_busy", busy, 1);
        check("dry_word_cnt", word_cnt, 256);
        check("dry_dones", dones, 0);
        check("dry_recv", recv, 256);
        check("dry_order", bad, 0);
        check("dry_strobes", rd_low, 257);
        check("dry_slrd_idle", bus.usb_slrd, 1);
        check("dry_slcs", bus.usb_slcs, 0);
        do_reset();

        // Zero-length transfer
        start_xfer(16'd0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        repeat (5) @(posedge usb_clk);
        #1;
        check("zero_strobes", rd_low, 0);
        check("zero_dones", dones, 1);

        // Reset mid-transfer, then restart
        start_xfer(16'd256);
        n = 0;
        while (word_cnt < 16'd50 && n < 1000) begin
            @(negedge usb_clk);
            n = n + 1;
        end
        check("mid_reached_50", word_cnt >= 16'd50, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid");
        do_reset();
        start_xfer(16'd20);
        check_arm("restart");
        wait_done(1000, ok);
        check("restart_done_seen", ok, 1);
        check("restart_word_cnt", word_cnt, 20);
        wait_recv(20, 1000);
        check("restart_recv", recv, 20);
        check("restart_order", bad, 0);
        check("restart_dones", dones, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb2_slvfifo_rd_ctrl.md
Name: usb2_slvfifo_rd_ctrl

Overview:
FPGA-side slave-FIFO read master for the USB2 download path. It drives the Cypress slave-FIFO control pins (usb_slcs, usb_sloe, usb_slrd, usb_fifoaddr) and samples usb_fd while usb_flaga reports data. It buffers the captured 16-bit words in a small FIFO and presents them on a valid/ready stream to the downstream flash-programming logic. It consumes exactly the interface that usb2_cyp_vip produces in simulation.

Parameters:
DEPTH, 8, output buffer depth in words; power of two, minimum 4.
EP_ADDR, 2'b00, value driven on usb_fifoaddr while a transfer is active.

Ports:
usb_clk  input  1  single clock, same as the slave-FIFO interface clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle pulse; begins a transfer; ignored unless idle.
cfg_words  input  16  number of words to read; sampled on start.
usb_fifoaddr  output  2  endpoint select.
usb_slcs  output  1  chip select, active low.
usb_sloe  output  1  output enable, active low.
usb_slrd  output  1  read strobe, active low; registered.
usb_fd  input  16  data bus; the top level instantiates the IOBUF with T=1.
usb_flaga  input  1  1 = endpoint has data.
m_data  output  16  stream data, taken from the buffer head.
m_valid  output  1  stream valid.
m_ready  input  1  stream ready.
busy  output  1  transfer in progress.
done  output  1  one-cycle pulse when the final word has been captured.
word_cnt  output  16  words captured in the current transfer.

Behaviour:
- Reset values:
  - usb_slcs=1, usb_sloe=1, usb_slrd=1, usb_fifoaddr=2'b00.
  - m_valid=0, busy=0, done=0, word_cnt=0.
  - Buffer empty; FSM in IDLE.
  - Reset mid-transfer aborts immediately. Buffered data is lost; no done pulse.
- FSM states:
  - IDLE
    - start with cfg_words==0: go to FIN.
    - start otherwise: latch cfg_words into len, clear word_cnt, go to ARM.
  - ARM, one cycle: usb_slcs=0, usb_sloe=0, usb_fifoaddr=EP_ADDR; then READ.
  - READ: slcs/sloe stay asserted. Leave for FIN on the edge where word_cnt reaches len.
  - FIN, one cycle: done=1, slcs/sloe/slrd deasserted, fifoaddr=0; then IDLE.
- busy=1 in ARM and READ.
- Read strobe: registered. usb_slrd_next is low only when all of the following hold:
  - state is READ;
  - usb_flaga=1;
  - buffer free entries >= 2 (one read may already be in flight);
  - word_cnt + (usb_slrd==0 ? 1 : 0) < len.
- Capture rule:
  - A word is captured at a rising edge only if usb_slrd==0 and usb_flaga==1 at that edge.
  - On capture, usb_fd is pushed into the buffer and word_cnt increments.
  - An edge with slrd low and flaga low captures nothing. This covers the word after flaga falls.
- Flaga low in READ: strobe stops; the block waits in READ indefinitely, with no timeout, until flaga rises again.
- Buffer behaviour:
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - The buffer never overflows, guaranteed by the free>=2 rule; overflow is an assertion failure.
  - Pop happens on m_valid && m_ready. m_data is stable while m_valid=1 and m_ready=0.
- Draining: done is signalled at capture completion, not at drain. The buffer keeps draining in IDLE, and a new start is accepted while it still holds data.
- word_cnt uses 16-bit unsigned arithmetic; it never exceeds len, so there is no wrap.

Optional Feature:
USB_RD_CHECKSUM_EN
- Defined:
  - Adds output rd_sum[15:0], the modulo-2^16 sum of all words captured in the transfer.
  - rd_sum clears on an accepted start and is final when done pulses.
- Undefined: no port and no logic.

Decomposition:
- Package usb2_slvfifo_pkg holds:
  - the state enum (IDLE, ARM, READ, FIN);
  - EP_ADDR default constants for EP2/EP4/EP6/EP8;
  - the word width constant of 16.
- Sub-module usb2_rd_buf: synchronous FIFO with DEPTH parameter, push/pop, and a free-count output.

Test Plan:
- Single full transfer: VIP with 256 words; cfg_words=256, m_ready=1, start → stream carries 0..255 in order; done pulses once; word_cnt=256; slrd high after the last capture.
- Partial transfer: cfg_words=100 → exactly 100 words (0..99); slrd never low for a 101st capture; busy=0 after FIN.
- Backpressure: cfg_words=256; m_ready toggles 1 cycle on, 3 off → no lost or duplicated words; buffer never overflows; slrd pauses whenever free<2.
- Source runs dry: cfg_words=300 → 256 words captured; the word after flaga falls is discarded; stays in READ with busy=1 and no done.
- cfg_words=0: start → done pulses within 2 cycles; slrd never asserted.
- Reset and restart: rst_n low mid-transfer (word_cnt≈50) → all outputs return to reset values immediately; a later start operates normally.
- Checksum, with USB_RD_CHECKSUM_EN and cfg_words=256: rd_sum=16'h7F80 at done.
